// File: rtl/noc_injection_controller.sv
`default_nettype none
// ============================================================================
// Module  : noc_injection_controller
// Purpose : Rate-limited round-robin packet injector with a network-wide cap.
// Revision: 1.0
// ============================================================================
module noc_injection_controller #(
    parameter int          NUM_NODES     = 16,
    parameter int          PIR           = 255,
    parameter int          MAX_INFLIGHT  = 32,
    parameter logic [31:0] RUN_CYCLES    = 32'd1000,
    parameter logic [31:0] DRAIN_TIMEOUT = 32'd4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] src_busy,
    input  logic [NUM_NODES-1:0] pkt_delivered,
    output logic [NUM_NODES-1:0] send,
    output logic [1:0]           state,
    output logic [31:0]          inj_count,
    output logic [31:0]          dlv_count,
    output logic [7:0]           inflight,
    output logic                 done,
    output logic                 timeout,
    output logic                 error
);
    localparam int              c_PW         = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int              c_IW         = c_PW + 1;
    localparam logic [c_IW-1:0] c_N          = c_IW'(NUM_NODES);
    localparam logic [8:0]      c_MAX        = 9'(MAX_INFLIGHT);
    localparam logic [7:0]      c_PIR        = 8'(PIR);
    localparam bit              c_PIR_ALL    = (PIR >= 255);
    localparam logic [31:0]     c_RUN_LAST   = RUN_CYCLES - 32'd1;
    localparam logic [31:0]     c_DRAIN_LAST = DRAIN_TIMEOUT - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_start_d;
    logic [NUM_NODES-1:0] r_send;
    logic [c_PW-1:0]      r_ptr;
    logic [31:0]          r_cyc;
    logic [31:0]          r_inj;
    logic [31:0]          r_dlv;
    logic [7:0]           r_inflight;
    logic                 r_timeout;
    logic                 r_error;

    logic                 w_rise;
    logic                 w_run_last;
    logic [NUM_NODES-1:0] w_dlv;
    logic [NUM_NODES-1:0] w_elig;
    logic [NUM_NODES-1:0] w_grant;
    logic                 w_grant_any;
    logic [c_PW-1:0]      w_next_ptr;
    logic [31:0]          w_pop_send;
    logic [31:0]          w_pop_dlv;
    logic [31:0]          w_total;
    logic [31:0]          w_diff;
    logic                 w_underflow;
    logic [7:0]           w_inflight_next;
    logic [8:0]           w_slots;

    function automatic logic [31:0] popcount(input logic [NUM_NODES-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < NUM_NODES; i++) n = n + {31'd0, v[i]};
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign w_rise      = start & ~r_start_d;
    assign w_run_last  = (r_cyc == c_RUN_LAST);
    assign w_dlv       = (r_state == S_IDLE) ? '0 : pkt_delivered;
    assign w_pop_send  = popcount(r_send);
    assign w_pop_dlv   = popcount(w_dlv);
    assign w_total     = {24'd0, r_inflight} + w_pop_send;
    assign w_diff      = w_total - w_pop_dlv;
    assign w_underflow = (w_pop_dlv > w_total);

    always_comb begin
        if (w_underflow)             w_inflight_next = 8'd0;
        else if (w_diff > 32'd255)   w_inflight_next = 8'hFF;
        else                         w_inflight_next = w_diff[7:0];
    end

    // Slots are judged against next cycle's inflight so pulses already on send count.
    assign w_slots = ({1'b0, w_inflight_next} >= c_MAX) ? 9'd0 : (c_MAX - {1'b0, w_inflight_next});

    for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node
        localparam int         c_SEED_I = (gi + 1) % 256;
        localparam logic [7:0] c_SEED   = (c_SEED_I == 0) ? 8'd1 : 8'(c_SEED_I);
        logic [7:0] r_lfsr;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                r_lfsr <= c_SEED;
            else if (r_state == S_RUN)
                r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end

        assign w_elig[gi] = ~src_busy[gi] & ~r_send[gi] & (c_PIR_ALL | (r_lfsr < c_PIR));
    end

    always_comb begin
        logic [8:0]      used;
        logic [c_IW-1:0] idx;
        w_grant    = '0;
        w_next_ptr = r_ptr;
        used       = 9'd0;
        idx        = '0;
        // No grants in the final RUN cycle: their pulse would land in DRAIN.
        if (r_state == S_RUN && !w_run_last) begin
            for (int k = 0; k < NUM_NODES; k++) begin
                idx = {1'b0, r_ptr} + c_IW'(k);
                if (idx >= c_N) idx = idx - c_N;
                if (w_elig[idx[c_PW-1:0]] && used < w_slots) begin
                    w_grant[idx[c_PW-1:0]] = 1'b1;
                    used       = used + 9'd1;
                    w_next_ptr = ((idx + c_IW'(1)) == c_N) ? '0 : c_PW'(idx + c_IW'(1));
                end
            end
        end
    end

    assign w_grant_any = |w_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_start_d  <= 1'b0;
            r_send     <= '0;
            r_ptr      <= '0;
            r_cyc      <= 32'd0;
            r_inj      <= 32'd0;
            r_dlv      <= 32'd0;
            r_inflight <= 8'd0;
            r_timeout  <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_start_d  <= start;
            r_send     <= w_grant;
            r_inflight <= w_inflight_next;
            r_inj      <= sat_add(r_inj, w_pop_send);
            r_dlv      <= sat_add(r_dlv, w_pop_dlv);
            if (w_underflow) r_error <= 1'b1;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_rise) begin
                        r_state    <= S_RUN;
                        r_inj      <= 32'd0;
                        r_dlv      <= 32'd0;
                        r_inflight <= 8'd0;
                        r_error    <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_cyc      <= 32'd0;
                        r_ptr      <= '0;
                    end
                end
                S_RUN: begin
                    if (w_grant_any) r_ptr <= w_next_ptr;
                    if (w_run_last) begin
                        r_state <= S_DRAIN;
                        r_cyc   <= 32'd0;
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == 8'd0) begin
                        r_state <= S_DONE;
                    end else if (r_cyc == c_DRAIN_LAST) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign send      = r_send;
    assign state     = r_state;
    assign inj_count = r_inj;
    assign dlv_count = r_dlv;
    assign inflight  = r_inflight;
    assign done      = (r_state == S_DONE);
    assign timeout   = r_timeout;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_noc_injection_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_noc_injection_controller
// Purpose : Directed and randomized checks of noc_injection_controller.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_noc_injection_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: N=4, full rate, cap 2, drain timeout 5
    logic       start_a;
    logic [3:0] busy_a, dlv_a, send_a;
    logic [1:0] state_a;
    logic [31:0] inj_a, dlvc_a;
    logic [7:0] infl_a;
    logic       done_a, to_a, err_a;

    noc_injection_controller #(.NUM_NODES(4), .PIR(255), .MAX_INFLIGHT(2),
                               .RUN_CYCLES(32'd40), .DRAIN_TIMEOUT(32'd5)) u_a (
        .clk(clk), .reset(rst_n), .start(start_a), .src_busy(busy_a), .pkt_delivered(dlv_a),
        .send(send_a), .state(state_a), .inj_count(inj_a), .dlv_count(dlvc_a),
        .inflight(infl_a), .done(done_a), .timeout(to_a), .error(err_a));

    // ---------------- instance B: alternating pattern with 3-cycle echo
    logic       start_b;
    logic [3:0] busy_b, dlv_b, send_b;
    logic [1:0] state_b;
    logic [31:0] inj_b, dlvc_b;
    logic [7:0] infl_b;
    logic       done_b, to_b, err_b;
    logic [3:0] pipe0 = '0, pipe1 = '0, pipe2 = '0;

    noc_injection_controller #(.NUM_NODES(4), .PIR(255), .MAX_INFLIGHT(32),
                               .RUN_CYCLES(32'd10), .DRAIN_TIMEOUT(32'd4096)) u_b (
        .clk(clk), .reset(rst_n), .start(start_b), .src_busy(busy_b), .pkt_delivered(dlv_b),
        .send(send_b), .state(state_b), .inj_count(inj_b), .dlv_count(dlvc_b),
        .inflight(infl_b), .done(done_b), .timeout(to_b), .error(err_b));

    // ---------------- instance C: PIR=0
    logic       start_c;
    logic [3:0] busy_c, dlv_c, send_c;
    logic [1:0] state_c;
    logic [31:0] inj_c, dlvc_c;
    logic [7:0] infl_c;
    logic       done_c, to_c, err_c;

    noc_injection_controller #(.NUM_NODES(4), .PIR(0), .MAX_INFLIGHT(4),
                               .RUN_CYCLES(32'd8), .DRAIN_TIMEOUT(32'd16)) u_c (
        .clk(clk), .reset(rst_n), .start(start_c), .src_busy(busy_c), .pkt_delivered(dlv_c),
        .send(send_c), .state(state_c), .inj_count(inj_c), .dlv_count(dlvc_c),
        .inflight(infl_c), .done(done_c), .timeout(to_c), .error(err_c));

    // ---------------- instance R: randomized, checked against the model
    localparam int RN = 5, RPIR = 100, RMAX = 6, RRUN = 200, RDT = 30;
    logic          start_r;
    logic [RN-1:0] busy_r, dlv_r, send_r;
    logic [1:0]    state_r;
    logic [31:0]   inj_r, dlvc_r;
    logic [7:0]    infl_r;
    logic          done_r, to_r, err_r;

    noc_injection_controller #(.NUM_NODES(RN), .PIR(RPIR), .MAX_INFLIGHT(RMAX),
                               .RUN_CYCLES(32'(RRUN)), .DRAIN_TIMEOUT(32'(RDT))) u_r (
        .clk(clk), .reset(rst_n), .start(start_r), .src_busy(busy_r), .pkt_delivered(dlv_r),
        .send(send_r), .state(state_r), .inj_count(inj_r), .dlv_count(dlvc_r),
        .inflight(infl_r), .done(done_r), .timeout(to_r), .error(err_r));

    // Reference model state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
    int            m_state, m_ptr, m_cyc, m_infl;
    longint        m_inj, m_dlv;
    bit            m_err, m_to, m_start_d;
    logic [7:0]    m_lfsr [RN];
    logic [RN-1:0] m_send;
    int            pend [RN];

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_cyc = 0; m_infl = 0;
        m_inj = 0; m_dlv = 0; m_err = 0; m_to = 0; m_start_d = 0;
        m_send = '0;
        for (int i = 0; i < RN; i++) begin
            m_lfsr[i] = 8'(i + 1);
            pend[i]   = 0;
        end
    endtask

    task automatic model_step();
        int ps, pd, tot, nxt, slots, idx, last_g, old;
        bit rise;
        logic [RN-1:0] g;
        rise = start_r && !m_start_d;
        m_start_d = start_r;
        ps  = $countones(m_send);
        pd  = (m_state == 0) ? 0 : $countones(dlv_r);
        tot = m_infl + ps;
        if (pd > tot) begin m_err = 1; nxt = 0; end
        else nxt = tot - pd;
        m_inj += ps; if (m_inj > 64'hFFFF_FFFF) m_inj = 64'hFFFF_FFFF;
        m_dlv += pd; if (m_dlv > 64'hFFFF_FFFF) m_dlv = 64'hFFFF_FFFF;
        g = '0;
        old = m_infl;
        m_infl = nxt;
        case (m_state)
            1: begin
                if (m_cyc < RRUN - 1) begin
                    slots  = RMAX - nxt;
                    if (slots < 0) slots = 0;
                    last_g = -1;
                    for (int k = 0; k < RN; k++) begin
                        idx = (m_ptr + k) % RN;
                        if (slots > 0 && !busy_r[idx] && !m_send[idx] && m_lfsr[idx] < RPIR) begin
                            g[idx] = 1'b1;
                            slots--;
                            last_g = idx;
                        end
                    end
                    if (last_g >= 0) m_ptr = (last_g + 1) % RN;
                    m_cyc++;
                end else begin
                    m_state = 2;
                    m_cyc   = 0;
                end
                for (int k = 0; k < RN; k++) m_lfsr[k] = lfsr_next(m_lfsr[k]);
            end
            2: begin
                if (old == 0) m_state = 3;
                else if (m_cyc == RDT - 1) begin m_state = 3; m_to = 1; end
                else m_cyc++;
            end
            default: begin
                if (rise) begin
                    m_state = 1; m_inj = 0; m_dlv = 0; m_infl = 0;
                    m_err = 0; m_to = 0; m_cyc = 0; m_ptr = 0;
                end
            end
        endcase
        m_send = g;
    endtask

    task automatic compare_r();
        check_val("r_send",     send_r,  m_send);
        check_val("r_state",    state_r, m_state);
        check_val("r_inflight", infl_r,  m_infl);
        check_val("r_inj",      inj_r,   m_inj);
        check_val("r_dlv",      dlvc_r,  m_dlv);
        check_val("r_flags",    {done_r, to_r, err_r}, {m_state == 3, m_to, m_err});
    endtask

    // One clock of the randomized instance; p_dlv is delivery probability in percent.
    task automatic cyc_r(input int p_dlv);
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        compare_r();
        for (int i = 0; i < RN; i++) if (m_send[i]) pend[i]++;
        busy_r = RN'($urandom & $urandom);
        dlv_r  = '0;
        for (int i = 0; i < RN; i++) begin
            if (pend[i] > 0 && int'($urandom_range(99)) < p_dlv) begin
                dlv_r[i] = 1'b1;
                pend[i]--;
            end else if (p_dlv > 0 && $urandom_range(299) == 0) begin
                dlv_r[i] = 1'b1;
            end
        end
    endtask

    // Echo every send of instance B back as a delivery three cycles later.
    initial begin
        forever begin
            @(negedge clk);
            dlv_b = pipe2;
            pipe2 = pipe1;
            pipe1 = pipe0;
            pipe0 = send_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses;
        logic [7:0] infl_at_drain;
        rst_n = 1'b1;
        start_a = 0; busy_a = '0; dlv_a = '0;
        start_b = 0; busy_b = '0;
        start_c = 0; busy_c = '0; dlv_c = '0;
        start_r = 0; busy_r = '0; dlv_r = '0;
        dlv_b = '0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("a_reset_state", state_a, 0);
        check_val("a_reset_send",  send_a, 0);
        check_val("a_reset_infl",  infl_a, 0);
        check_val("a_reset_inj",   inj_a, 0);
        check_val("a_reset_flags", {done_a, to_a, err_a}, 0);

        // Full rate, cap 2
        start_a = 1;
        @(negedge clk);
        check_val("a_run_entry", state_a, 1);
        check_val("a_run_send0", send_a, 0);
        @(negedge clk);
        check_val("a_first_grant", send_a, 4'b0011);
        @(negedge clk);
        check_val("a_cap_block", send_a, 4'b0000);
        check_val("a_cap_infl",  infl_a, 2);
        @(negedge clk);
        check_val("a_cap_hold", send_a, 4'b0000);
        dlv_a = 4'b0001;
        @(negedge clk);
        dlv_a = 4'b0000;
        check_val("a_regrant_node2", send_a, 4'b0100);
        check_val("a_regrant_infl",  infl_a, 1);
        @(negedge clk);
        check_val("a_single_pulse", send_a, 4'b0000);
        check_val("a_infl_back2",   infl_a, 2);

        // Drain timeout with deliveries suppressed
        for (int i = 0; i < 100 && state_a != 2; i++) @(negedge clk);
        check_val("a_enter_drain", state_a, 2);
        infl_at_drain = infl_a;
        n = 0;
        while (state_a != 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("a_drain_len",    n, 5);
        check_val("a_timeout",      to_a, 1);
        check_val("a_done",         done_a, 1);
        check_val("a_infl_at_done", infl_a, 2);
        check_val("a_infl_kept",    infl_a, infl_at_drain);
        repeat (3) @(negedge clk);
        check_val("a_held_start_no_retrigger", state_a, 3);

        // Spurious delivery right after a new run starts
        start_a = 0;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        check_val("a_rerun", state_a, 1);
        dlv_a = 4'b0001;
        @(negedge clk);
        dlv_a = 4'b0000;
        check_val("a_spur_error", err_a, 1);
        check_val("a_spur_infl",  infl_a, 0);
        check_val("a_spur_dlv",   dlvc_a, 1);
        check_val("a_rerun_to_clr", to_a, 0);
        check_val("a_rerun_ptr_clr", send_a, 4'b0011);

        // Alternating pattern with echo
        start_b = 1;
        for (int i = 0; i < 5 && state_b != 1; i++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check_val("b_run_state", state_b, 1);
            check_val("b_alt_send",  send_b, (k % 2 == 1) ? 4'hF : 4'h0);
            @(negedge clk);
        end
        check_val("b_drain_entry", state_b, 2);
        check_val("b_drain_send",  send_b, 0);
        for (int i = 0; i < 50 && state_b != 3; i++) @(negedge clk);
        check_val("b_done",    state_b, 3);
        check_val("b_inj",     inj_b, 20);
        check_val("b_dlv",     dlvc_b, 20);
        check_val("b_timeout", to_b, 0);

        // PIR = 0
        start_c = 1;
        pulses = 0;
        for (int i = 0; i < 50 && state_c != 2; i++) begin
            @(negedge clk);
            pulses += $countones(send_c);
        end
        check_val("c_enter_drain", state_c, 2);
        n = 0;
        while (state_c != 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("c_drain_len", n, 1);
        check_val("c_pulses",    pulses, 0);
        check_val("c_inj",       inj_c, 0);

        // Randomized runs against the model
        for (int run = 0; run < 3; run++) begin
            start_r = 1;
            cyc_r(40);
            repeat ($urandom_range(3)) cyc_r(40);
            start_r = 0;
            for (int i = 0; i < 600 && m_state != 3; i++) begin
                start_r = (m_state == 1 && m_cyc >= 50 && m_cyc < 53);
                cyc_r((run == 1 && m_state == 2) ? 0 : 40);
            end
            check_val("r_run_ends", m_state, 3);
            start_r = 0;
            repeat (5) cyc_r(40);
        end

        // Reset mid-run
        start_r = 1;
        cyc_r(0);
        start_r = 0;
        for (int i = 0; i < 100 && m_infl < 5; i++) cyc_r(0);
        check_val("r_infl_reached", m_infl >= 5, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_send",  send_r, 0);
        check_val("rst_state", state_r, 0);
        check_val("rst_infl",  infl_r, 0);
        check_val("rst_inj",   inj_r, 0);
        check_val("rst_dlv",   dlvc_r, 0);
        check_val("rst_flags", {done_r, to_r, err_r}, 0);
        model_reset();
        dlv_r = '0;
        repeat (2) cyc_r(0);
        rst_n = 1'b1;
        repeat (10) cyc_r(40);
        start_r = 1;
        cyc_r(40);
        start_r = 0;
        for (int i = 0; i < 600 && m_state != 3; i++) cyc_r(40);
        check_val("r_post_reset_run", m_state, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
